// File: rtl/packet_sender.sv
// packet_sender: serialises one 40-bit packet {dest[7:0], payload[31:0]}
// into a FLAG-delimited, byte-stuffed stream for one 8-bit mesh edge input.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no frame, out_byte = IDLE_BYTE, ready to accept
// S_SOF   | opening FLAG on out_byte
// S_FIELD | field idx_q on out_byte (raw byte, or ESC if it needs stuffing)
// S_ESC2  | stuffed field byte (byte ^ XOR_MASK) on out_byte
// S_EOF   | closing FLAG on out_byte, frame_done asserted
// S_GAP   | IDLE_BYTE gap, gap_q counts down to 0 (last cycle is ready)
module packet_sender #(
    parameter logic [7:0]  FLAG      = 8'h7E,
    parameter logic [7:0]  ESC       = 8'h7D,
    parameter logic [7:0]  XOR_MASK  = 8'h20,
    parameter logic [7:0]  IDLE_BYTE = 8'h00,
    parameter int unsigned GAP_BYTES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [39:0] in_pkt,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_byte,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOF,
        S_FIELD,
        S_ESC2,
        S_EOF,
        S_GAP
    } state_t;

    localparam logic [3:0] GAP_LOAD = 4'(GAP_BYTES - 1);

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [3:0]  gap_q, gap_d;
    logic [39:0] hold_q;
    logic [7:0]  out_q, out_d;
    logic        busy_q;
    logic        done_q;
    logic [15:0] frame_count_q;

    logic        accept;
    logic        advance;
    logic [7:0]  cur_byte;
    logic [7:0]  nxt_byte;
    logic [7:0]  first_byte;

    // Field i of the held packet, MSB-first: dest, then payload bytes.
    function automatic logic [7:0] field_byte(input logic [2:0] idx, input logic [39:0] pkt);
        logic [7:0] b;
        case (idx)
            3'd0:    b = pkt[39:32];
            3'd1:    b = pkt[31:24];
            3'd2:    b = pkt[23:16];
            3'd3:    b = pkt[15:8];
            default: b = pkt[7:0];
        endcase
        return b;
    endfunction

    function automatic logic needs_esc(input logic [7:0] b);
        return (b == FLAG) || (b == ESC);
    endfunction

    assign in_ready    = (state_q == S_IDLE) || ((state_q == S_GAP) && (gap_q == 4'd0));
    assign accept      = in_valid && in_ready;
    assign out_byte    = out_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign frame_count = frame_count_q;

    assign cur_byte   = field_byte(idx_q, hold_q);
    assign nxt_byte   = field_byte(3'(idx_q + 3'd1), hold_q);
    assign first_byte = field_byte(3'd0, hold_q);

    // Next state and the byte that will be registered onto the link.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        out_d   = IDLE_BYTE;
        advance = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_SOF;
                    out_d   = FLAG;
                end
            end
            S_SOF: begin
                state_d = S_FIELD;
                idx_d   = 3'd0;
                out_d   = needs_esc(first_byte) ? ESC : first_byte;
            end
            S_FIELD: begin
                if (needs_esc(cur_byte)) begin
                    state_d = S_ESC2;
                    out_d   = cur_byte ^ XOR_MASK;
                end else begin
                    advance = 1'b1;
                end
            end
            S_ESC2: begin
                advance = 1'b1;
            end
            S_EOF: begin
                state_d = S_GAP;
                gap_d   = GAP_LOAD;
                out_d   = IDLE_BYTE;
            end
            S_GAP: begin
                if (gap_q == 4'd0) begin
                    if (accept) begin
                        state_d = S_SOF;
                        out_d   = FLAG;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Move on to the next field, or close the frame after the last one.
        if (advance) begin
            if (idx_q == 3'd4) begin
                state_d = S_EOF;
                out_d   = FLAG;
            end else begin
                state_d = S_FIELD;
                idx_d   = 3'(idx_q + 3'd1);
                out_d   = needs_esc(nxt_byte) ? ESC : nxt_byte;
            end
        end
    end

    // State, registered link outputs and frame counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            idx_q         <= 3'd0;
            gap_q         <= 4'd0;
            out_q         <= IDLE_BYTE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            out_q   <= out_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_EOF);
            if (state_q == S_EOF) begin
                frame_count_q <= frame_count_q + 16'd1;
            end
        end
    end

    // Packet hold register; in_pkt is free to change once accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q <= 40'd0;
        end else if (accept) begin
            hold_q <= in_pkt;
        end
    end

endmodule

// File: tb/tb_packet_sender.sv
module tb_packet_sender;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [39:0] in_pkt = 40'd0;
    logic        in_valid = 1'b0;
    logic        in_valid3 = 1'b0;
    logic        in_ready, in_ready3;
    logic [7:0]  out_byte, out_byte3;
    logic        busy, busy3;
    logic        frame_done, frame_done3;
    logic [15:0] frame_count, frame_count3;

    int n_chk = 0;
    int n_err = 0;
    int exp_cnt = 0;

    // entry = {in_ready, frame_done, out_byte}
    logic [9:0] q1[$];
    logic [9:0] q3[$];

    always #5 clk = ~clk;

    packet_sender #(.GAP_BYTES(1)) dut (
        .clk(clk), .rst(rst), .in_pkt(in_pkt), .in_valid(in_valid),
        .in_ready(in_ready), .out_byte(out_byte), .busy(busy),
        .frame_done(frame_done), .frame_count(frame_count)
    );

    packet_sender #(.GAP_BYTES(3)) dut3 (
        .clk(clk), .rst(rst), .in_pkt(in_pkt), .in_valid(in_valid3),
        .in_ready(in_ready3), .out_byte(out_byte3), .busy(busy3),
        .frame_done(frame_done3), .frame_count(frame_count3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Hand-expanded wire image of one frame, including the gap bytes.
    task automatic push_frame(input logic [39:0] p, input bit use3);
        logic [7:0] f[5];
        logic [9:0] e[$];
        int gap;
        gap  = use3 ? 3 : 1;
        f[0] = p[39:32]; f[1] = p[31:24]; f[2] = p[23:16]; f[3] = p[15:8]; f[4] = p[7:0];
        e.push_back({2'b00, 8'h7E});
        for (int i = 0; i < 5; i++) begin
            if (f[i] == 8'h7E || f[i] == 8'h7D) begin
                e.push_back({2'b00, 8'h7D});
                e.push_back({2'b00, f[i] ^ 8'h20});
            end else begin
                e.push_back({2'b00, f[i]});
            end
        end
        e.push_back({2'b01, 8'h7E});
        for (int g = 0; g < gap; g++) e.push_back({(g == gap - 1), 1'b0, 8'h00});
        foreach (e[k]) begin
            if (use3) q3.push_back(e[k]);
            else      q1.push_back(e[k]);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [39:0] p, input bit use3, input bit keep);
        int t;
        bit acc;
        t = 0;
        in_pkt = p;
        if (use3) in_valid3 = 1'b1; else in_valid = 1'b1;
        do begin
            acc = use3 ? in_ready3 : in_ready;
            @(posedge clk); #1;
            t++;
        end while (!acc && t < 50);
        if (!acc) chk("accept timeout", 32'(t), 32'd0);
        else push_frame(p, use3);
        if (!keep) begin
            in_valid  = 1'b0;
            in_valid3 = 1'b0;
            in_pkt    = 40'h7E7D7E7D7E;
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || busy3 || q1.size() != 0 || q3.size() != 0) && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 200) chk("idle timeout", 32'(t), 32'd0);
        @(posedge clk); #1;
    endtask

    // Scoreboard monitors: pop one expected entry per busy cycle.
    always @(negedge clk) begin
        if (busy) begin
            if (q1.size() == 0) chk("dut byte unexpected", {22'd0, in_ready, frame_done, out_byte}, 32'hFFFF);
            else chk("dut byte", {22'd0, in_ready, frame_done, out_byte}, {22'd0, q1.pop_front()});
        end else begin
            chk("dut idle", {22'd0, in_ready, frame_done, out_byte}, {22'd0, 2'b10, 8'h00});
            chk("dut pending at idle", q1.size(), 0);
        end
    end

    always @(negedge clk) begin
        if (busy3) begin
            if (q3.size() == 0) chk("dut3 byte unexpected", {22'd0, in_ready3, frame_done3, out_byte3}, 32'hFFFF);
            else chk("dut3 byte", {22'd0, in_ready3, frame_done3, out_byte3}, {22'd0, q3.pop_front()});
        end else begin
            chk("dut3 idle", {22'd0, in_ready3, frame_done3, out_byte3}, {22'd0, 2'b10, 8'h00});
            chk("dut3 pending at idle", q3.size(), 0);
        end
    end

    initial begin
        #1;
        chk("reset out_byte", out_byte, 8'h00);
        chk("reset busy", busy, 0);
        chk("reset in_ready", in_ready, 1);
        chk("reset frame_count", frame_count, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // basic frame
        send({8'h23, 32'hDEADBEEF}, 0, 0);
        wait_idle();
        exp_cnt = 1;
        chk("basic frame_count", frame_count, exp_cnt);

        // escaping in dest and payload
        send({8'h7D, 32'h7E7D0120}, 0, 0);
        wait_idle();
        exp_cnt = 2;
        chk("escape frame_count", frame_count, exp_cnt);

        // back-to-back with valid held
        send({8'h45, 32'hCAFEBABE}, 0, 1);
        send({8'h12, 32'h01234567}, 0, 0);
        wait_idle();
        exp_cnt = 4;
        chk("b2b frame_count", frame_count, exp_cnt);

        // three-byte gap instance
        send({8'h31, 32'h00207E55}, 1, 0);
        wait_idle();
        chk("gap3 frame_count", frame_count3, 1);

        // asynchronous reset while payload[23:16] is on the link
        send({8'h23, 32'h11223344}, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("pre-reset byte", out_byte, 8'h22);
        #1;
        rst = 1'b0;
        #1;
        chk("mid reset out_byte", out_byte, 8'h00);
        chk("mid reset busy", busy, 0);
        chk("mid reset in_ready", in_ready, 1);
        chk("mid reset frame_count", frame_count, 0);
        chk("mid reset frame_count3", frame_count3, 0);
        q1.delete();
        q3.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        send({8'hA7, 32'h7D00FF7E}, 0, 0);
        wait_idle();
        chk("post reset frame_count", frame_count, 1);

        // counter wrap from a preloaded FFFF
        force dut.frame_count_q = 16'hFFFF;
        #1;
        release dut.frame_count_q;
        @(posedge clk); #1;
        chk("preload frame_count", frame_count, 16'hFFFF);
        send({8'h56, 32'h89ABCDEF}, 0, 0);
        wait_idle();
        chk("wrap frame_count", frame_count, 16'h0000);

        chk("final queue dut", q1.size(), 0);
        chk("final queue dut3", q3.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/packet_sender.md
Name: packet_sender

Overview:
Hardware framer that serialises one packet_t (x_dest, y_dest, 32-bit payload) into the byte-stuffed link format consumed by the mesh edge inputs (south_in/north_in/west_in/east_in) and decoded by packet_receiver. It is the upstream stage feeding a router edge port, and it replaces bench-side byte-banging with a synthesizable source. One packet_sender drives one 8-bit edge input.

Parameters:
FLAG, 8'h7E, frame delimiter byte.
ESC, 8'h7D, escape byte.
XOR_MASK, 8'h20, value XORed into an escaped byte.
IDLE_BYTE, 8'h00, byte driven when no frame is active.
GAP_BYTES, 1, number of IDLE_BYTE cycles after the closing FLAG; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low (asserted when 0)
in_pkt  input  packet_t (40)  packet to send; dest = {x_dest, y_dest}
in_valid  input  1  in_pkt is valid
in_ready  output  1  sender can accept in_pkt this cycle
out_byte  output  8  link byte to the router edge input, registered
busy  output  1  frame or gap in progress
frame_done  output  1  one-cycle pulse while the closing FLAG is on out_byte
frame_count  output  16  frames completed since reset, wraps at 16'hFFFF -> 0

Behaviour:
- Reset (rst=0, asynchronous): out_byte=IDLE_BYTE, in_ready=1, busy=0, frame_done=0, frame_count=0, state=IDLE. Any frame in flight is dropped with no closing FLAG.
- Handshake: transfer when in_valid && in_ready at a rising edge. in_pkt is captured into an internal hold register and may change afterwards. When in_ready=0, in_valid may be held and nothing is lost.
- in_ready is combinational from state. It is 1 in IDLE and during the last GAP cycle; it is 0 otherwise.
- States: IDLE -> SOF -> FIELD(i=0..4) [-> ESC2] -> EOF -> GAP(n) -> IDLE, or -> SOF if accepted on the last GAP cycle.
- Latency: the cycle after the accept edge, out_byte=FLAG (SOF).
- Field order, MSB first: i=0 dest, i=1 payload[31:24], i=2 [23:16], i=3 [15:8], i=4 [7:0]. One byte per cycle.
- Escaping: if a field byte equals FLAG or ESC, emit ESC in that cycle, then (byte ^ XOR_MASK) in the next cycle (ESC2), then advance i. All other values, including 8'h00 and 8'h20, are emitted raw. The opening and closing FLAGs are never escaped.
- EOF: out_byte=FLAG and frame_done=1 for exactly that cycle. frame_count increments at the end of the EOF cycle.
- GAP: out_byte=IDLE_BYTE for GAP_BYTES cycles, counted down by a 4-bit counter.
- Frame length on the wire = 7 + (number of escaped fields) + GAP_BYTES cycles; range 8..13 for GAP_BYTES=1.
- Back-to-back: with in_valid held high, the next SOF immediately follows the last gap byte. There are no extra idle cycles.
- busy=1 from SOF through the last GAP cycle inclusive.
- out_byte, busy and frame_done are registered outputs (flop outputs), glitch-free.
- No output depends on in_pkt after capture.

Test Plan:
- Basic frame: in_pkt dest 8'h23, payload 32'hDEADBEEF, one-cycle valid from IDLE -> out_byte 7E,23,DE,AD,BE,EF,7E,00 on consecutive cycles, then 00 steady. frame_done high only on the second 7E; frame_count=1.
- Escaping: dest 8'h7D, payload 32'h7E7D0120 -> 7E,7D,5D,7D,5E,7D,5D,01,20,7E,00 (11 cycles). busy high for 11 cycles. A packet_receiver on out_byte reports x_dest=7, y_dest=D, payload=7E7D0120 with out_valid.
- Back-to-back with backpressure: in_valid held across two packets (payloads CAFEBABE, 01234567) -> in_ready=0 throughout frame 1 except its 00 gap cycle. Frame 2's 7E follows that 00 directly. frame_count=2, and packet 2 is not corrupted by in_pkt changing while in_ready=0.
- GAP_BYTES=3: single packet -> three 00 bytes after the closing 7E. in_ready rises only on the third gap cycle.
- Reset mid-frame: assert rst=0 asynchronously while payload[23:16] is on out_byte -> out_byte=00, busy=0, in_ready=1 and frame_count=0 immediately. After release, a new packet produces a clean full frame.
- Counter wrap: force 65536 frames (or preload via a bench-only force) -> frame_count goes FFFF -> 0000 on the EOF of frame 65536.
